if_prefetch_stage: RTL

Parametrised instruction-fetch stage with a prefetch buffer and a pipelined instruction-memory request/response interface. It keeps up to DEPTH instructions buffered or in flight, delivers them in order to the ID stage under freeze control, and redirects on branchTaken. On a redirect it flushes the buffer and discards any in-flight responses. It sits between the PC/branch logic of EXE and the IF/ID pipeline register, and replaces the single-cycle PC + memory fetch path.

---
 rtl/if_prefetch_stage.sv | 112 +++++++++++
 1 files changed

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a DEPTH-entry prefetch ring and a pipelined
// request/grant/response memory port, delivering in order to ID with redirect flush.
module if_prefetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branchTaken,
    input  logic [ADDR_W-1:0]  branchAddress,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  PC,
    output logic [INSTR_W-1:0] instruction
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 2;

    // One ring holds every entry in order: [head, resp) buffered, [resp, issue) in flight.
    logic [ADDR_W-1:0]  addrQueue [DEPTH];
    logic [INSTR_W-1:0] dataBuf   [DEPTH];
    logic [PTR_W-1:0]   headPtr;
    logic [PTR_W-1:0]   respPtr;
    logic [PTR_W-1:0]   issuePtr;
    logic [CNT_W-1:0]   bufCount;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   dropCount;
    logic [ADDR_W-1:0]  fetchPc;

    logic [SUM_W-1:0]   occupancy;
    logic               issue;
    logic               rspDrop;
    logic               rspAccept;
    logic               bufValid;
    logic               pop;

    // Stale responses still occupy capacity so the ring can never be overrun.
    assign occupancy = SUM_W'(bufCount) + SUM_W'(outstanding) + SUM_W'(dropCount);
    assign imem_req  = occupancy < SUM_W'(DEPTH);
    assign imem_addr = fetchPc;

    assign issue     = imem_req && imem_gnt;
    assign rspDrop   = imem_rvalid && (dropCount != '0);
    assign rspAccept = imem_rvalid && (dropCount == '0) && (outstanding != '0);
    assign bufValid  = bufCount != '0;
    assign pop       = bufValid && !freeze;

    assign if_valid    = bufValid;
    assign PC          = bufValid ? addrQueue[headPtr] + ADDR_W'(4) : '0;
    assign instruction = bufValid ? dataBuf[headPtr] : '0;

    // NOTE: storage arrays are not reset; the pointers and counters alone decide
    // which slots are meaningful, so clearing the data would only cost a reset tree.
    always_ff @(posedge clk) begin
        if (issue) begin
            addrQueue[issuePtr] <= fetchPc;
        end
        if (rspAccept) begin
            dataBuf[respPtr] <= imem_rdata;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every update reads
    // the pre-edge values, matching the combinational terms computed above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc     <= RESET_PC;
            headPtr     <= '0;
            respPtr     <= '0;
            issuePtr    <= '0;
            bufCount    <= '0;
            outstanding <= '0;
            dropCount   <= '0;
        end else if (branchTaken) begin
            // Everything issued before or during this edge belongs to the old stream.
            fetchPc     <= branchAddress;
            headPtr     <= '0;
            respPtr     <= '0;
            issuePtr    <= '0;
            bufCount    <= '0;
            outstanding <= '0;
            dropCount   <= dropCount + outstanding + CNT_W'(issue)
                           - CNT_W'(rspDrop || rspAccept);
        end else begin
            if (issue) begin
                issuePtr <= issuePtr + PTR_W'(1);
                fetchPc  <= fetchPc + ADDR_W'(4);
            end
            if (rspDrop) begin
                dropCount <= dropCount - CNT_W'(1);
            end
            if (rspAccept) begin
                respPtr <= respPtr + PTR_W'(1);
            end
            if (pop) begin
                headPtr <= headPtr + PTR_W'(1);
            end
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(rspAccept);
            bufCount    <= bufCount + CNT_W'(rspAccept) - CNT_W'(pop);
        end
    end

endmodule
